// File: rtl/nice_sched_pkg.sv
// rtl/nice_sched_pkg.sv - shared types and constants for the FIR channel scheduler
//
// Purpose: FSM state encoding, default sample width and the signed sample type
// shared by the scheduler RTL and its bench.
package nice_sched_pkg;

    localparam int SCHED_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    typedef logic signed [SCHED_DATA_W-1:0] sample_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts inc_i pulses and sticks at all-ones; clr_i has priority.
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   clr_i           : synchronous clear to zero
//   inc_i           : increment request
//   cnt_o           : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// rtl/fir_channel_scheduler.sv - time-multiplexes one FIR/MAC engine across NUM_CH channels
//
// Purpose: on each frame tick, snapshot all channel samples, issue them one at a
// time to the shared engine, collect results and publish one aligned frame.
// Ports:
//   clk_i, reset_ni          : clock, asynchronous active-low reset
//   tick_i, data_i           : frame strobe and packed samples (ch0 in LSBs)
//   eng_start_o/ch_o/data_o  : request to the shared engine
//   eng_done_i, eng_data_i   : engine result
//   data_o, done_o           : published frame and its one-cycle valid
//   busy_o                   : high outside IDLE
//   err_o, err_clr_i         : sticky per-channel timeout flags and their clear
//   ovr_cnt_o                : saturating count of dropped ticks
module fir_channel_scheduler
    import nice_sched_pkg::*;
#(
    parameter  int NUM_CH  = 2,
    parameter  int DATA_W  = SCHED_DATA_W,
    parameter  int TIMEOUT = 255,
    parameter  int OVR_W   = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     tick_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    output logic                     eng_start_o,
    output logic [CH_W-1:0]          eng_ch_o,
    output logic [DATA_W-1:0]        eng_data_o,
    input  logic                     eng_done_i,
    input  logic [DATA_W-1:0]        eng_data_i,
    output logic [NUM_CH*DATA_W-1:0] data_o,
    output logic                     done_o,
    output logic                     busy_o,
    output logic [NUM_CH-1:0]        err_o,
    input  logic                     err_clr_i,
    output logic [OVR_W-1:0]         ovr_cnt_o
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t                   state, next_state;
    logic [CH_W-1:0]          idx, idx_d, idx_inc;
    logic [DATA_W-1:0]        snap     [NUM_CH];
    logic [DATA_W-1:0]        result   [NUM_CH];
    logic [DATA_W-1:0]        result_d [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] frame_d;
    logic [DATA_W-1:0]        eng_data_d;
    logic [NUM_CH-1:0]        err_d;
    logic [TO_W-1:0]          to_cnt;
    logic                     last_ch, wait_done, wait_to, advance, accept, drop;

    assign idx_inc   = idx + CH_W'(1);
    assign last_ch   = (idx == CH_W'(NUM_CH - 1));
    assign wait_done = (state == WAIT) && eng_done_i;
    // A done arriving on the expiry cycle wins, so expiry requires no done.
    assign wait_to   = (state == WAIT) && !eng_done_i && (to_cnt == TO_W'(TIMEOUT));
    assign advance   = wait_done || wait_to;
    // PUBLISH can take a new tick directly, so frames may run back to back.
    assign accept    = tick_i && ((state == IDLE) || (state == PUBLISH));
    assign drop      = tick_i && ((state == ISSUE) || (state == WAIT));

    sat_counter #(.W(OVR_W)) u_ovr_cnt (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clr_i    (1'b0),
        .inc_i    (drop),
        .cnt_o    (ovr_cnt_o)
    );

    // Cleared in ISSUE so each WAIT starts counting from zero.
    sat_counter #(.W(TO_W)) u_timeout_cnt (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clr_i    (state == ISSUE),
        .inc_i    ((state == WAIT) && !eng_done_i),
        .cnt_o    (to_cnt)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tick_i) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (advance) next_state = last_ch ? PUBLISH : ISSUE;
            PUBLISH: next_state = tick_i ? ISSUE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        idx_d      = idx;
        result_d   = result;
        frame_d    = '0;
        eng_data_d = accept ? data_i[DATA_W-1:0] : snap[idx_inc];
        if (accept) begin
            idx_d = '0;
        end else if (advance && !last_ch) begin
            idx_d = idx_inc;
        end
        // On timeout result[idx] is left alone so the last good value is republished.
        if (wait_done) begin
            result_d[idx] = eng_data_i;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            frame_d[i*DATA_W +: DATA_W] = result_d[i];
        end
        err_d = err_clr_i ? '0 : err_o;
        if (wait_to) begin
            err_d[idx] = 1'b1;
        end
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            idx         <= '0;
            eng_start_o <= 1'b0;
            eng_ch_o    <= '0;
            eng_data_o  <= '0;
            data_o      <= '0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap[i]   <= '0;
                result[i] <= '0;
            end
        end else begin
            idx <= idx_d;
            for (int i = 0; i < NUM_CH; i++) begin
                result[i] <= result_d[i];
                if (accept) begin
                    snap[i] <= data_i[i*DATA_W +: DATA_W];
                end
            end
            eng_start_o <= (next_state == ISSUE);
            if (next_state == ISSUE) begin
                eng_ch_o   <= idx_d;
                eng_data_o <= eng_data_d;
            end
            done_o <= (next_state == PUBLISH);
            if (next_state == PUBLISH) begin
                data_o <= frame_d;
            end
            busy_o <= (next_state != IDLE);
            err_o  <= err_d;
        end
    end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// tb/tb_fir_channel_scheduler.sv - self-checking bench for fir_channel_scheduler
module tb_fir_channel_scheduler;
    import nice_sched_pkg::*;

    localparam int NCH = 2;
    localparam int DW  = 24;
    localparam int TMO = 10;
    localparam int OW  = 4;
    localparam int L   = 3;

    logic              clk = 1'b0;
    logic              reset_ni;
    logic              tick_i;
    logic [NCH*DW-1:0] data_i;
    logic              eng_start_o;
    logic [0:0]        eng_ch_o;
    logic [DW-1:0]     eng_data_o;
    logic              eng_done_i;
    logic [DW-1:0]     eng_data_i;
    logic [NCH*DW-1:0] data_o;
    logic              done_o;
    logic              busy_o;
    logic [NCH-1:0]    err_o;
    logic              err_clr_i;
    logic [OW-1:0]     ovr_cnt_o;

    always #5 clk = ~clk;

    fir_channel_scheduler #(
        .NUM_CH(NCH), .DATA_W(DW), .TIMEOUT(TMO), .OVR_W(OW)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .tick_i      (tick_i),
        .data_i      (data_i),
        .eng_start_o (eng_start_o),
        .eng_ch_o    (eng_ch_o),
        .eng_data_o  (eng_data_o),
        .eng_done_i  (eng_done_i),
        .eng_data_i  (eng_data_i),
        .data_o      (data_o),
        .done_o      (done_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .err_clr_i   (err_clr_i),
        .ovr_cnt_o   (ovr_cnt_o)
    );

    // Engine model: result = sample + 1, L cycles after start; muted channels never answer.
    int            eng_cd = 0;
    logic [DW-1:0] eng_pend = '0;
    logic          model_done = 1'b0;
    logic [DW-1:0] model_data = '0;
    logic [1:0]    mute = 2'b00;
    logic          spur_done = 1'b0;
    logic [DW-1:0] spur_val = '0;

    assign eng_done_i = model_done | spur_done;
    assign eng_data_i = spur_done ? spur_val : model_data;

    always @(posedge clk) begin
        #1;
        model_done = 1'b0;
        if (eng_cd > 0) begin
            eng_cd = eng_cd - 1;
            if (eng_cd == 0) begin
                model_done = 1'b1;
                model_data = eng_pend + DW'(1);
            end
        end
        if (eng_start_o && !mute[eng_ch_o]) begin
            eng_cd   = L;
            eng_pend = eng_data_o;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int failures = 0;
    int t0 = 0;
    int rel = 0;
    int last_res [NCH];

    logic [NCH*DW-1:0] exp_q[$];
    logic [NCH*DW-1:0] dn_data[$];
    int                dn_rel[$];
    int                st_rel[$];
    int                st_ch[$];
    logic              busy_h [64];
    logic [NCH-1:0]    err_h [64];
    logic [OW-1:0]     ovr_h [64];
    logic [NCH*DW-1:0] got;
    logic [NCH*DW-1:0] want;

    function automatic logic [NCH*DW-1:0] pack2(input int c0, input int c1);
        sample_t a, b;
        a = c0[DW-1:0];
        b = c1[DW-1:0];
        return {b, a};
    endfunction

    task automatic clear_rec();
        dn_data.delete();
        dn_rel.delete();
        st_rel.delete();
        st_ch.delete();
        for (int i = 0; i < 64; i++) begin
            busy_h[i] = 1'b0;
            err_h[i]  = '0;
            ovr_h[i]  = '0;
        end
    endtask

    // Advance one clock and record what the DUT shows in the new cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        rel = cyc - t0;
        if (rel >= 0 && rel < 64) begin
            busy_h[rel] = busy_o;
            err_h[rel]  = err_o;
            ovr_h[rel]  = ovr_cnt_o;
        end
        if (eng_start_o) begin
            st_rel.push_back(rel);
            st_ch.push_back(int'(eng_ch_o));
        end
        if (done_o) begin
            dn_rel.push_back(rel);
            dn_data.push_back(data_o);
        end
    endtask

    // Scoreboard push for an accepted tick whose channels all answer.
    task automatic expect_frame(input int c0, input int c1);
        last_res[0] = c0 + 1;
        last_res[1] = c1 + 1;
        exp_q.push_back(pack2(last_res[0], last_res[1]));
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        tick_i = 1'b0;
        data_i = pack2(55, 66);
        err_clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({eng_start_o, done_o, busy_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=000", {eng_start_o, done_o, busy_o});
        end
        checks++;
        if ({data_o, eng_data_o, eng_ch_o} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", data_o, eng_data_o, eng_ch_o);
        end
        checks++;
        if ({err_o, ovr_cnt_o} !== '0) begin
            failures++;
            $display("FAIL reset_err_ovr got=%b/%0d exp=0/0", err_o, ovr_cnt_o);
        end
        reset_ni = 1'b1;
        last_res[0] = 0;
        last_res[1] = 0;
        clear_rec();
        t0 = cyc;
        cycle();
        cycle();
        checks++;
        if (busy_h[1] !== 1'b0 || busy_h[2] !== 1'b0 || st_rel.size() != 0) begin
            failures++;
            $display("FAIL reset_idle got=busy%b starts%0d exp=busy0 starts0", busy_h[2], st_rel.size());
        end
    endtask

    task automatic test_single_frame();
        clear_rec();
        t0 = cyc;
        data_i = pack2(100, -5);
        tick_i = 1'b1;
        expect_frame(100, -5);
        cycle();
        tick_i = 1'b0;
        repeat (12) cycle();
        checks++;
        if (st_rel.size() != 2 || st_rel[0] != 1 || st_rel[1] != 5) begin
            failures++;
            $display("FAIL single_start_cycles got=%p exp='{1,5}", st_rel);
        end
        checks++;
        if (st_ch.size() != 2 || st_ch[0] != 0 || st_ch[1] != 1) begin
            failures++;
            $display("FAIL single_start_ch got=%p exp='{0,1}", st_ch);
        end
        checks++;
        if (dn_rel.size() != 1 || dn_rel[0] != 9) begin
            failures++;
            $display("FAIL single_done_cycle got=%p exp='{9}", dn_rel);
        end
        want = exp_q.pop_front();
        got = (dn_data.size() > 0) ? dn_data[0] : 'x;
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL single_data got=%h exp=%h", got, want);
        end
        checks++;
        if (busy_h[9] !== 1'b1 || busy_h[10] !== 1'b0) begin
            failures++;
            $display("FAIL single_busy got=%b%b exp=10", busy_h[9], busy_h[10]);
        end
    endtask

    task automatic test_back_to_back();
        clear_rec();
        t0 = cyc;
        for (int r = 0; r < 25; r++) begin
            tick_i = 1'b0;
            if (r == 0) begin
                tick_i = 1'b1;
                data_i = pack2(10, 20);
                expect_frame(10, 20);
            end else if (r == 4) begin
                tick_i = 1'b1;
                data_i = pack2(77, 88);
            end else if (r == 9) begin
                tick_i = 1'b1;
                data_i = pack2(-100, 300);
                expect_frame(-100, 300);
            end else begin
                data_i = pack2(r, r);
            end
            cycle();
        end
        tick_i = 1'b0;
        checks++;
        if (ovr_cnt_o !== OW'(1)) begin
            failures++;
            $display("FAIL b2b_ovr got=%0d exp=1", ovr_cnt_o);
        end
        checks++;
        if (st_rel.size() != 4 || st_rel[0] != 1 || st_rel[1] != 5 || st_rel[2] != 10 || st_rel[3] != 14) begin
            failures++;
            $display("FAIL b2b_starts got=%p exp='{1,5,10,14}", st_rel);
        end
        checks++;
        if (dn_rel.size() != 2 || dn_rel[0] != 9 || dn_rel[1] != 18) begin
            failures++;
            $display("FAIL b2b_done got=%p exp='{9,18}", dn_rel);
        end
        for (int k = 0; k < 2; k++) begin
            want = exp_q.pop_front();
            got = (dn_data.size() > k) ? dn_data[k] : 'x;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL b2b_data%0d got=%h exp=%h", k, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        mute = 2'b10;
        clear_rec();
        t0 = cyc;
        data_i = pack2(7, 9);
        tick_i = 1'b1;
        last_res[0] = 8;
        exp_q.push_back(pack2(last_res[0], last_res[1]));
        cycle();
        tick_i = 1'b0;
        repeat (20) cycle();
        mute = 2'b00;
        checks++;
        if (err_h[16] !== 2'b00 || err_h[17] !== 2'b10) begin
            failures++;
            $display("FAIL timeout_err_timing got=%b,%b exp=00,10", err_h[16], err_h[17]);
        end
        checks++;
        if (dn_rel.size() != 1 || dn_rel[0] != 17) begin
            failures++;
            $display("FAIL timeout_done got=%p exp='{17}", dn_rel);
        end
        want = exp_q.pop_front();
        got = (dn_data.size() > 0) ? dn_data[0] : 'x;
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL timeout_data got=%h exp=%h", got, want);
        end
        checks++;
        if (err_o !== 2'b10) begin
            failures++;
            $display("FAIL timeout_sticky got=%b exp=10", err_o);
        end
        err_clr_i = 1'b1;
        cycle();
        err_clr_i = 1'b0;
        checks++;
        if (err_o !== 2'b00) begin
            failures++;
            $display("FAIL timeout_clear got=%b exp=00", err_o);
        end
    endtask

    task automatic test_overrun_sat();
        mute = 2'b11;
        clear_rec();
        t0 = cyc;
        exp_q.push_back(pack2(last_res[0], last_res[1]));
        for (int r = 0; r < 29; r++) begin
            tick_i = (r <= 20);
            data_i = pack2(50 + r, 60 + r);
            cycle();
        end
        tick_i = 1'b0;
        mute = 2'b00;
        checks++;
        if (ovr_h[14] !== OW'(14) || ovr_h[15] !== OW'(15)) begin
            failures++;
            $display("FAIL ovr_ramp got=%0d,%0d exp=14,15", ovr_h[14], ovr_h[15]);
        end
        checks++;
        if (ovr_cnt_o !== OW'(15)) begin
            failures++;
            $display("FAIL ovr_saturate got=%0d exp=15", ovr_cnt_o);
        end
        checks++;
        if (dn_rel.size() != 1 || dn_rel[0] != 25) begin
            failures++;
            $display("FAIL ovr_done got=%p exp='{25}", dn_rel);
        end
        want = exp_q.pop_front();
        got = (dn_data.size() > 0) ? dn_data[0] : 'x;
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL ovr_held_data got=%h exp=%h", got, want);
        end
        checks++;
        if (err_o !== 2'b11) begin
            failures++;
            $display("FAIL ovr_err got=%b exp=11", err_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_rec();
        t0 = cyc;
        for (int r = 0; r < 3; r++) begin
            tick_i = (r == 0);
            data_i = pack2(1234, 5);
            cycle();
        end
        tick_i = 1'b0;
        reset_ni = 1'b0;
        #1;
        checks++;
        if ({eng_start_o, done_o, busy_o, eng_ch_o, eng_data_o, data_o, err_o, ovr_cnt_o} !== '0) begin
            failures++;
            $display("FAIL midreset_async got=busy%b eng%h data%h err%b ovr%0d exp=all0",
                     busy_o, eng_data_o, data_o, err_o, ovr_cnt_o);
        end
        repeat (3) cycle();
        reset_ni = 1'b1;
        repeat (3) cycle();
        last_res[0] = 0;
        last_res[1] = 0;
        checks++;
        if (dn_rel.size() != 0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_done got=dones%0d busy%b exp=dones0 busy0", dn_rel.size(), busy_o);
        end
        clear_rec();
        t0 = cyc;
        data_i = pack2(40, -40);
        tick_i = 1'b1;
        expect_frame(40, -40);
        cycle();
        tick_i = 1'b0;
        repeat (11) cycle();
        checks++;
        if (st_rel.size() != 2 || st_rel[0] != 1 || st_ch[0] != 0 || st_ch[1] != 1) begin
            failures++;
            $display("FAIL midreset_restart got=%p/%p exp='{1,5}/'{0,1}", st_rel, st_ch);
        end
        want = exp_q.pop_front();
        got = (dn_data.size() > 0 && dn_rel[0] == 9) ? dn_data[0] : 'x;
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL midreset_data got=%h exp=%h", got, want);
        end
    endtask

    task automatic test_spurious_done();
        want = pack2(last_res[0], last_res[1]);
        clear_rec();
        t0 = cyc;
        spur_val = DW'(999);
        spur_done = 1'b1;
        cycle();
        spur_done = 1'b0;
        cycle();
        cycle();
        checks++;
        if (st_rel.size() != 0 || dn_rel.size() != 0 || busy_h[1] !== 1'b0 || busy_h[2] !== 1'b0) begin
            failures++;
            $display("FAIL spur_idle got=starts%0d dones%0d busy%b exp=0,0,0", st_rel.size(), dn_rel.size(), busy_h[2]);
        end
        checks++;
        if (data_o !== want) begin
            failures++;
            $display("FAIL spur_idle_data got=%h exp=%h", data_o, want);
        end
        clear_rec();
        t0 = cyc;
        data_i = pack2(1000, -2000);
        tick_i = 1'b1;
        expect_frame(1000, -2000);
        cycle();
        tick_i = 1'b0;
        spur_done = 1'b1;
        cycle();
        spur_done = 1'b0;
        repeat (10) cycle();
        checks++;
        if (st_rel.size() != 2 || st_rel[0] != 1 || st_rel[1] != 5 || dn_rel.size() != 1 || dn_rel[0] != 9) begin
            failures++;
            $display("FAIL spur_issue_timing got=%p/%p exp='{1,5}/'{9}", st_rel, dn_rel);
        end
        want = exp_q.pop_front();
        got = (dn_data.size() > 0) ? dn_data[0] : 'x;
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL spur_issue_data got=%h exp=%h", got, want);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_timeout();
        test_overrun_sat();
        test_reset_mid_frame();
        test_spurious_done();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
